// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared state type, accumulate-length helper and lane default for conv_tile_controller
package conv_ctrl_pkg;

    localparam int PE_NUM_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } conv_ctrl_state_t;

    // One 32-bit BRAM word carries four 8-bit input channels.
    function automatic int acc_len(input int kw, input int ic);
        return kw * kw * ic / 4;
    endfunction

endpackage

// File: rtl/conv_tile_controller_if.sv
// rtl/conv_tile_controller_if.sv - datapath handshake bundle between the controller and BRAM/addr-gen/PE cluster/OFM sink
interface conv_tile_controller_if #(
    parameter int PE_NUM = conv_ctrl_pkg::PE_NUM_DEFAULT
);
    logic              addr_gen_ready;
    logic [PE_NUM-1:0] PE_en;
    logic [PE_NUM-1:0] PE_finish;
    logic [PE_NUM-1:0] valid;
    logic              ofm_we;
    logic [31:0]       ofm_addr;
    logic              ofm_stall;

    modport master (
        output addr_gen_ready, PE_en, PE_finish, ofm_we, ofm_addr,
        input  valid, ofm_stall
    );

    modport slave (
        input  addr_gen_ready, PE_en, PE_finish, ofm_we, ofm_addr,
        output valid, ofm_stall
    );
endinterface

// File: rtl/conv_step_counter.sv
// rtl/conv_step_counter.sv - issue/pixel/group counters with terminal flags; forms the OFM word address
module conv_step_counter #(
    parameter int ACC_LEN = 36,
    parameter int PIX     = 3136,
    parameter int GROUPS  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        issue_inc,
    input  logic        step_inc,
    output logic        issue_last,
    output logic        step_last,
    output logic [31:0] ofm_addr
);
    localparam int IW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int PW = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    logic [IW-1:0] issue_cnt;
    logic [PW-1:0] pix_cnt;
    logic [GW-1:0] grp_cnt;
    logic          pix_last;
    logic          grp_last;

    assign issue_last = (issue_cnt == IW'(ACC_LEN - 1));
    assign pix_last   = (pix_cnt == PW'(PIX - 1));
    assign grp_last   = (grp_cnt == GW'(GROUPS - 1));
    assign step_last  = pix_last && grp_last;

    // Group is the outer loop, pixel the inner one.
    assign ofm_addr = 32'(grp_cnt) * 32'(PIX) + 32'(pix_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt <= '0;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
        end else begin
            if (issue_inc) begin
                issue_cnt <= issue_last ? '0 : issue_cnt + 1'b1;
            end
            if (step_inc) begin
                if (pix_last) begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/conv_tile_controller.sv
// rtl/conv_tile_controller.sv - layer sequencer: issue, drain, OFM write per step; CONV_CTRL_PERF_EN adds perf counters
module conv_tile_controller
    import conv_ctrl_pkg::*;
#(
    parameter int KERNEL_W = 3,
    parameter int IFM_C    = 16,
    parameter int OFM_W    = 56,
    parameter int OFM_H    = 56,
    parameter int OFM_C    = 32,
    parameter int PE_NUM   = PE_NUM_DEFAULT,
    parameter int BRAM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    conv_tile_controller_if.master dp,
    output logic                   busy,
    output logic                   done
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stall
`endif
);
    localparam int ACC_LEN = acc_len(KERNEL_W, IFM_C);
    localparam int GROUPS  = OFM_C / PE_NUM;
    localparam int PIX     = OFM_W * OFM_H;

    conv_ctrl_state_t    state;
    logic                ready_q;
    logic                we_q;
    logic [BRAM_LAT-1:0] iss_sr;
    logic [BRAM_LAT-1:0] last_sr;
    logic                issue_last;
    logic                step_last;
    logic [31:0]         addr_w;
    logic                launch;
    logic                xfer;
    logic                pipe_empty;

    assign launch     = (state == ST_IDLE) && start && !abort;
    assign xfer       = (state == ST_WRITE) && !dp.ofm_stall && !abort;
    assign pipe_empty = ~|iss_sr;

    conv_step_counter #(
        .ACC_LEN (ACC_LEN),
        .PIX     (PIX),
        .GROUPS  (GROUPS)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (abort || launch),
        .issue_inc  (ready_q && !abort),
        .step_inc   (xfer),
        .issue_last (issue_last),
        .step_last  (step_last),
        .ofm_addr   (addr_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
        end else if (abort) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_ISSUE;
                    busy    <= 1'b1;
                    ready_q <= 1'b1;
                end
                ST_ISSUE: if (issue_last) begin
                    state   <= ST_DRAIN;
                    ready_q <= 1'b0;
                end
                // Partial lane valid is not enough; every lane must report.
                ST_DRAIN: if (pipe_empty && &dp.valid) begin
                    state <= ST_WRITE;
                    we_q  <= 1'b1;
                end
                ST_WRITE: if (!dp.ofm_stall) begin
                    we_q <= 1'b0;
                    if (step_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= ST_ISSUE;
                        ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Delay issue/last by the BRAM read latency so PE strobes line up with read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_sr  <= '0;
            last_sr <= '0;
        end else if (abort) begin
            iss_sr  <= '0;
            last_sr <= '0;
        end else begin
            iss_sr[0]  <= ready_q;
            last_sr[0] <= ready_q && issue_last;
            for (int i = 1; i < BRAM_LAT; i++) begin
                iss_sr[i]  <= iss_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign dp.addr_gen_ready = ready_q;
    assign dp.PE_en          = {PE_NUM{iss_sr[BRAM_LAT-1]}};
    assign dp.PE_finish      = {PE_NUM{last_sr[BRAM_LAT-1]}};
    assign dp.ofm_we         = we_q;
    assign dp.ofm_addr       = addr_w;

`ifdef CONV_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (launch) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            perf_cycles <= perf_cycles + 32'(busy);
            perf_stall  <= perf_stall + 32'(we_q && dp.ofm_stall);
        end
    end
`endif
endmodule

// File: tb/tb_conv_tile_controller.sv
// tb/tb_conv_tile_controller.sv - directed bench with a timeline model for conv_tile_controller
module tb_conv_tile_controller;
    localparam int ACC   = 36;
    localparam int LAT   = 1;
    localparam int STEPS = 8;

    logic clk = 1'b0;
    logic reset_n, start, abort, busy, done;
`ifdef CONV_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    conv_tile_controller_if #(.PE_NUM(16)) dp_if ();

    conv_tile_controller #(
        .KERNEL_W(3), .IFM_C(16), .OFM_W(2), .OFM_H(2),
        .OFM_C(32), .PE_NUM(16), .BRAM_LAT(LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .dp          (dp_if),
        .busy        (busy),
        .done        (done)
`ifdef CONV_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit vforce = 1'b0;
    logic [15:0] vval = 16'hFFFF;
    int xfer_cnt = 0, done_cnt = 0, last_xfer_cyc = 0, done_cyc = 0;
    logic [31:0] addr_log [16];

    // Model: timestamps of the current step rather than controller states.
    bit m_active = 0, m_done = 0, m_writing = 0;
    int m_t_issue = -1000, m_step = 0, d;
    int unsigned m_pc = 0, m_ps = 0;
    bit e_ready, e_en, e_fin, e_we;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_we(input int lim);
        int n = 0;
        while (!dp_if.ofm_we && n < lim) begin
            tick();
            n++;
        end
        chk("wait_we", 32'(dp_if.ofm_we), 32'd1);
    endtask

    // Cluster responder: all lanes valid two cycles after PE_finish unless forced.
    initial begin
        int vcnt = 0;
        dp_if.valid = '0;
        forever begin
            @(posedge clk);
            #1;
            if (vforce) dp_if.valid = vval;
            else if (dp_if.ofm_we || !busy) begin
                dp_if.valid = '0;
                vcnt = 0;
            end else if (dp_if.PE_finish[0]) vcnt = 2;
            else if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) dp_if.valid = '1;
            end
        end
    end

    // Compare process: check every cycle, then advance the model with this cycle's inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_active = 0; m_done = 0; m_writing = 0; m_step = 0;
                m_t_issue = -1000; m_pc = 0; m_ps = 0;
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_ready", 32'(dp_if.addr_gen_ready), 0);
                chk("rst_pe_en", 32'(dp_if.PE_en), 0);
                chk("rst_we", 32'(dp_if.ofm_we), 0);
                chk("rst_addr", dp_if.ofm_addr, 0);
            end else begin
                d = cyc - m_t_issue;
                e_ready = m_active && !m_done && !m_writing && d >= 0 && d < ACC;
                e_en    = m_active && !m_done && d >= LAT && d <= ACC - 1 + LAT;
                e_fin   = m_active && !m_done && d == ACC - 1 + LAT;
                e_we    = m_active && !m_done && m_writing;
                chk("busy", 32'(busy), 32'(m_active));
                chk("done", 32'(done), 32'(m_done));
                chk("ready", 32'(dp_if.addr_gen_ready), 32'(e_ready));
                chk("pe_en", 32'(dp_if.PE_en), e_en ? 32'hFFFF : 32'h0);
                chk("pe_finish", 32'(dp_if.PE_finish), e_fin ? 32'hFFFF : 32'h0);
                chk("ofm_we", 32'(dp_if.ofm_we), 32'(e_we));
                if (e_we) chk("ofm_addr", dp_if.ofm_addr, 32'(m_step));
`ifdef CONV_CTRL_PERF_EN
                chk("perf_cycles", perf_cycles, m_pc);
                chk("perf_stall", perf_stall, m_ps);
`endif
                if (dp_if.ofm_we && !dp_if.ofm_stall) begin
                    if (xfer_cnt < 16) addr_log[xfer_cnt] = dp_if.ofm_addr;
                    xfer_cnt++;
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                m_pc += 32'(m_active);
                m_ps += 32'(e_we && dp_if.ofm_stall);
                if (abort) begin
                    m_active = 0; m_done = 0; m_writing = 0;
                end else if (m_done) begin
                    m_done = 0; m_active = 0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active = 1; m_writing = 0; m_step = 0;
                        m_t_issue = cyc + 1; m_pc = 0; m_ps = 0;
                    end
                end else if (m_writing) begin
                    if (!dp_if.ofm_stall) begin
                        m_writing = 0;
                        if (m_step == STEPS - 1) begin
                            m_done = 1; m_step = 0;
                        end else begin
                            m_step++; m_t_issue = cyc + 1;
                        end
                    end
                end else if (d >= ACC + LAT && &dp_if.valid) begin
                    m_writing = 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cs, n;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; dp_if.ofm_stall = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_addr", dp_if.ofm_addr, 0);

        // Full layer: 2 groups x 4 pixels, step 0 timed against literal cycles.
        start = 1'b1; cs = cyc; tick(); start = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            chk("s0_ready", 32'(dp_if.addr_gen_ready), 32'((k <= 36) || (k == 41)));
            chk("s0_pe_en", 32'(dp_if.PE_en), (k >= 2 && k <= 37) ? 32'hFFFF : 32'h0);
            chk("s0_finish", 32'(dp_if.PE_finish), (k == 37) ? 32'hFFFF : 32'h0);
            chk("s0_we", 32'(dp_if.ofm_we), 32'(k == 40));
            if (k == 40) chk("s0_addr", dp_if.ofm_addr, 0);
            chk("s0_rel", 32'(cyc - cs), 32'(k));
            tick();
        end
        wait_we(100);
        dp_if.ofm_stall = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("stall_we", 32'(dp_if.ofm_we), 1);
            chk("stall_addr", dp_if.ofm_addr, 1);
            tick();
        end
        dp_if.ofm_stall = 1'b0;
        chk("stall_we6", 32'(dp_if.ofm_we), 1);
        chk("stall_addr6", dp_if.ofm_addr, 1);
        tick();
        chk("post_stall_ready", 32'(dp_if.addr_gen_ready), 1);
        chk("post_stall_we", 32'(dp_if.ofm_we), 0);
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            tick();
            n++;
        end
        repeat (5) tick();
        chk("layer_writes", 32'(xfer_cnt), 8);
        chk("layer_done_cnt", 32'(done_cnt), 1);
        chk("done_latency", 32'(done_cyc - last_xfer_cyc), 1);
        for (int i = 0; i < 8; i++) chk("addr_order", addr_log[i], 32'(i));
        chk("layer_busy_end", 32'(busy), 0);
`ifdef CONV_CTRL_PERF_EN
        chk("perf_stall_5", perf_stall, 5);
`endif

        // Abort in ISSUE cycle 10.
        xfer_cnt = 0; done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        chk("abort_pre_ready", 32'(dp_if.addr_gen_ready), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_pe_en", 32'(dp_if.PE_en), 0);
        chk("abort_ready", 32'(dp_if.addr_gen_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (50) tick();
        chk("abort_no_done", 32'(done_cnt), 0);
        start = 1'b1; tick(); start = 1'b0;
        wait_we(100);
        chk("restart_addr", dp_if.ofm_addr, 0);

        // Partial valid with start pulsed in DRAIN.
        vforce = 1'b1; vval = 16'hFFFE;
        tick();
        chk("no_bubble_ready", 32'(dp_if.addr_gen_ready), 1);
        n = 0;
        while (dp_if.addr_gen_ready && n < 100) begin
            tick();
            n++;
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("partial_we", 32'(dp_if.ofm_we), 0);
            chk("partial_busy", 32'(busy), 1);
            tick();
        end
        vval = 16'hFFFF;
        wait_we(10);
        chk("partial_addr", dp_if.ofm_addr, 1);
        vforce = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("end_abort_busy", 32'(busy), 0);
        chk("end_abort_done", 32'(done_cnt), 0);

        // Asynchronous reset mid-ISSUE.
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_ready", 32'(dp_if.addr_gen_ready), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(dp_if.addr_gen_ready), 0);
        chk("arst_pe_en", 32'(dp_if.PE_en), 0);
        chk("arst_we", 32'(dp_if.ofm_we), 0);
`ifdef CONV_CTRL_PERF_EN
        chk("arst_perf", perf_cycles, 0);
`endif
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_tile_controller.md
# conv_tile_controller

Sequencer for the convolution sub-top. It accepts a single start command and steps through every output pixel and filter group of one layer. For each step it drives the address generator's `ready`, the PE cluster's `PE_en` and `PE_finish` lanes (aligned to BRAM read latency), waits for the cluster's `valid`, and emits one OFM write per step under output backpressure. It sits between the host/layer scheduler and the BRAM + address_generator + PE_cluster datapath.

## Interface
Parameters:
- `KERNEL_W`, 3, kernel width/height
- `IFM_C`, 16, input channels (multiple of 4; one 32-bit word carries 4 channels)
- `OFM_W`, 56, output width
- `OFM_H`, 56, output height
- `OFM_C`, 32, output channels (multiple of `PE_NUM`)
- `PE_NUM`, 16, PE lanes
- `BRAM_LAT`, 1, BRAM read latency in cycles (1..4)

Ports:
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch layer; sampled only in IDLE
- `abort`  in  1  synchronous cancel
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at layer completion
- `addr_gen_ready`  out  1  drives `address_generator.ready`; generator advances one word per high cycle
- `PE_en`  out  `PE_NUM`  per-lane accumulate enable
- `PE_finish`  out  `PE_NUM`  per-lane last-word strobe
- `valid`  in  `PE_NUM`  per-lane result valid from cluster
- `ofm_we`  out  1  OFM write request
- `ofm_addr`  out  32  OFM word address (one word = `PE_NUM` bytes)
- `ofm_stall`  in  1  sink backpressure; a write transfers when `ofm_we && !ofm_stall`

## Operation
- `ACC_LEN = KERNEL_W*KERNEL_W*IFM_C/4` (36 by default).
- `GROUPS = OFM_C/PE_NUM`.
- `PIX = OFM_W*OFM_H`.
- Loop order: group outer, pixel inner.
- `ofm_addr = group*PIX + pixel`.
- States and transitions:
  - IDLE: on `start`, clear counters and go to ISSUE.
  - ISSUE: `addr_gen_ready=1` for exactly `ACC_LEN` cycles, then go to DRAIN.
  - DRAIN: wait until the issue pipeline is empty and `&valid`, then go to WRITE.
  - WRITE: `ofm_we=1`; hold while stalled. On transfer, go to ISSUE for the next step, or to DONE after the last step.
  - DONE: `done=1` for one cycle, then go to IDLE.
- Issue pipeline: a `BRAM_LAT`-deep shift register carries (issue, last).
  - `PE_en = {PE_NUM{issue_d}}`.
  - `PE_finish = {PE_NUM{last_d}}`.
  - `PE_finish` is high in the same cycle as the final `PE_en`.
- Counters wrap to 0 at the end of each layer. Pixel and group counters saturate-check against `PIX-1` and `GROUPS-1`.
- `abort` in any state: the next state is IDLE, the pipeline is flushed, all strobes go to 0, and `done` does not pulse. `abort` has priority over `start` and over a transfer in the same cycle.
- `start` while `busy=1` is ignored.
- A partial `valid` (not all lanes high) is not sufficient; the controller stays in DRAIN.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pipeline empty.
- `start` is sampled at edge E0. ISSUE occupies cycles 1..`ACC_LEN`.
- `PE_en` is high in cycles 1+`BRAM_LAT` .. `ACC_LEN`+`BRAM_LAT`.
- `PE_finish` is high in cycle `ACC_LEN`+`BRAM_LAT` only.
- `ofm_we` rises in the cycle after `&valid` is seen in DRAIN, with `ofm_addr` stable.
- While `ofm_stall=1`, `ofm_we` and `ofm_addr` hold unchanged.
- After a transfer, the next ISSUE starts on the following cycle (no bubble).
- `done` pulses in the cycle after the final transfer; `busy` falls in the same cycle `done` falls.

## Configuration
- `CONV_CTRL_PERF_EN` defined: adds output ports `perf_cycles[31:0]` (counts busy cycles) and `perf_stall[31:0]` (counts `ofm_we && ofm_stall` cycles).
  - Both clear on `start` and hold after `done`.
  - Both are reset to 0 by `reset_n`.
- Macro undefined: these ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Shared package `conv_ctrl_pkg`: state enum `conv_ctrl_state_t`, function `acc_len(kw, ic)`, and a default `PE_NUM` constant.
- One sub-module, `conv_step_counter`: holds the issue, pixel and group counters with terminal-count flags, and drives `ofm_addr`.
- The top level holds the FSM and the latency shift register.

## Test plan
- Reset mid-ISSUE: assert `reset_n=0` -> all outputs 0 immediately; after release, `busy=0`.
- Single step, defaults, `valid` returned 2 cycles after `PE_finish`:
  - `addr_gen_ready` high in cycles 1..36.
  - `PE_en` high in cycles 2..37.
  - `PE_finish` high in cycle 37.
  - `ofm_we` high in cycle 40 with `ofm_addr=0`.
- `ofm_stall` held high for 5 cycles in WRITE -> `ofm_we`/`ofm_addr` stable for 6 cycles, the next ISSUE starts 1 cycle after release, and `perf_stall=5` when `CONV_CTRL_PERF_EN` is defined.
- `OFM_W=OFM_H=2`, `OFM_C=32` -> 8 writes with `ofm_addr` 0..7 in order, and `done` pulses exactly once, 1 cycle after the 8th transfer.
- `abort` in ISSUE cycle 10 -> next cycle `PE_en=0`, `addr_gen_ready=0`, `busy=0`, no `done`; a following `start` produces its first write with `ofm_addr=0`.
- `start` pulsed during DRAIN, and `valid=0xFFFE` for 20 cycles -> the `start` is ignored and the controller stays in DRAIN until `valid=0xFFFF`.
